// File: rtl/i2c_wb_arbiter_pkg.sv
// Shared types and the rotating-priority pick function for the I2C Wishbone arbiter.
// Covers i2c_wb_arbiter, including its optional I2C_WB_ARB_TIMEOUT_EN abort path.
package i2c_wb_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_ABORT} arb_state_t;

    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    // The pointer is PTR_W bits wide, so adding to it wraps modulo MAX_REQ.
    // Request bits at or above NUM_REQ are zero, which makes that wrap
    // equivalent to wrapping modulo NUM_REQ.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [PTR_W-1:0]   ptr);
        logic [MAX_REQ-1:0] gnt;
        logic [PTR_W-1:0]   idx;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/i2c_wb_arbiter_if.sv
// Bus bundle for the arbiter: the packed requester side and the downstream I2C core side.
// The slave modport is the arbiter's view. The master modport is the view of the hosts and the core.
interface i2c_wb_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADR_W   = 3,
    parameter int DAT_W   = 16,
    parameter int SEL_W   = 2
);
    logic [NUM_REQ-1:0]       req_cyc_i;
    logic [NUM_REQ-1:0]       req_stb_i;
    logic [NUM_REQ-1:0]       req_we_i;
    logic [NUM_REQ*ADR_W-1:0] req_adr_i;
    logic [NUM_REQ*DAT_W-1:0] req_dat_i;
    logic [NUM_REQ*SEL_W-1:0] req_sel_i;
    logic [DAT_W-1:0]         req_dat_o;
    logic [NUM_REQ-1:0]       req_ack_o;
    logic [NUM_REQ-1:0]       req_err_o;
    logic [NUM_REQ-1:0]       grant_o;

    logic                     wbs_cyc_o;
    logic                     wbs_stb_o;
    logic                     wbs_we_o;
    logic [ADR_W-1:0]         wbs_adr_o;
    logic [DAT_W-1:0]         wbs_dat_o;
    logic [SEL_W-1:0]         wbs_sel_o;
    logic [DAT_W-1:0]         wbs_dat_i;
    logic                     wbs_ack_i;

    modport slave (
        input  req_cyc_i, req_stb_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        input  wbs_dat_i, wbs_ack_i,
        output req_dat_o, req_ack_o, req_err_o, grant_o,
        output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o
    );

    modport master (
        output req_cyc_i, req_stb_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        output wbs_dat_i, wbs_ack_i,
        input  req_dat_o, req_ack_o, req_err_o, grant_o,
        input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o
    );
endinterface

// File: rtl/i2c_wb_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: the first requester at or after ptr_i wins.
// Its output is one-hot, or all zero when there is no request.
module i2c_wb_rr_pick
    import i2c_wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);
    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] gnt_ext;
    logic               unused_hi;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
    end

    assign gnt_ext   = rr_pick(req_ext, ptr_i);
    assign gnt_o     = gnt_ext[NUM_REQ-1:0];
    // Upper grant bits are always zero because their requests are tied off.
    assign unused_hi = ^gnt_ext;

endmodule

// File: rtl/i2c_wb_arbiter.sv
// Round-robin Wishbone arbiter that grants one requester per CYC frame in front of the I2C master core.
// Define I2C_WB_ARB_TIMEOUT_EN to enable the unacked-STB timeout abort (ERR pulse, ABORT state).
module i2c_wb_arbiter
    import i2c_wb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADR_W       = 3,
    parameter int DAT_W       = 16,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    i2c_wb_arbiter_if.slave  bus
);
    arb_state_t          state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_nxt_d;
    logic [NUM_REQ-1:0]  pick_d;
    logic [NUM_REQ-1:0]  cyc_eff;

    logic                mux_cyc;
    logic                mux_stb;
    logic                mux_we;
    logic [ADR_W-1:0]    mux_adr;
    logic [DAT_W-1:0]    mux_dat;
    logic [SEL_W-1:0]    mux_sel;

`ifdef I2C_WB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 255) ? 16 : 8;

    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_REQ-1:0]  err_q;
    logic [NUM_REQ-1:0]  mask_q;
    logic                to_hit;

    // An aborted owner stays masked until its CYC has been seen low once.
    assign cyc_eff       = bus.req_cyc_i & ~mask_q;
    assign to_hit        = (state_q == ARB_BUSY) && mux_stb && !bus.wbs_ack_i &&
                           (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign bus.req_err_o = err_q;
`else
    logic                unused_to;

    assign cyc_eff       = bus.req_cyc_i;
    assign bus.req_err_o = '0;
    assign unused_to     = (TIMEOUT_CYC == 0);
`endif

    i2c_wb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i (cyc_eff),
        .ptr_i (ptr_q),
        .gnt_o (pick_d)
    );

    always_comb begin
        ptr_nxt_d = ptr_q;
        for (int k = 0; k < NUM_REQ; k++)
            if (grant_q[k])
                ptr_nxt_d = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
    end

    // Downstream mux. grant_q is zero outside BUSY, so every output reads zero when the bus is idle.
    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        mux_we  = 1'b0;
        mux_adr = '0;
        mux_dat = '0;
        mux_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                mux_cyc = bus.req_cyc_i[k];
                mux_stb = bus.req_cyc_i[k] & bus.req_stb_i[k];
                mux_we  = bus.req_we_i[k];
                mux_adr = bus.req_adr_i[k*ADR_W +: ADR_W];
                mux_dat = bus.req_dat_i[k*DAT_W +: DAT_W];
                mux_sel = bus.req_sel_i[k*SEL_W +: SEL_W];
            end
        end
    end

    assign bus.wbs_cyc_o = mux_cyc;
    assign bus.wbs_stb_o = mux_stb;
    assign bus.wbs_we_o  = mux_we;
    assign bus.wbs_adr_o = mux_adr;
    assign bus.wbs_dat_o = mux_dat;
    assign bus.wbs_sel_o = mux_sel;
    assign bus.grant_o   = grant_q;
    // An ACK that arrives while the owner is dropping CYC is discarded.
    assign bus.req_ack_o = grant_q & bus.req_cyc_i & {NUM_REQ{bus.wbs_ack_i}};
    assign bus.req_dat_o = (|grant_q) ? bus.wbs_dat_i : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
`ifdef I2C_WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
`endif
        end else begin
`ifdef I2C_WB_ARB_TIMEOUT_EN
            err_q  <= '0;
            mask_q <= mask_q & bus.req_cyc_i;
            if (state_q != ARB_BUSY || !mux_cyc || to_hit || bus.wbs_ack_i)
                cnt_q <= '0;
            else if (mux_stb)
                cnt_q <= cnt_q + 1'b1;
`endif
            case (state_q)
                ARB_IDLE: begin
                    if (|cyc_eff) begin
                        grant_q <= pick_d;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (!mux_cyc) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_nxt_d;
                        state_q <= ARB_IDLE;
                    end
`ifdef I2C_WB_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_nxt_d;
                        err_q   <= grant_q;
                        mask_q  <= (mask_q & bus.req_cyc_i) | grant_q;
                        state_q <= ARB_ABORT;
                    end
`endif
                end
`ifdef I2C_WB_ARB_TIMEOUT_EN
                ARB_ABORT: state_q <= ARB_IDLE;
`endif
                default:   state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule
